lbp_scan_engine: RTL and testbench
==================================

# lbp_scan_engine

Parametrised successor to the 3x3 Local Binary Pattern block: it scans a W x H grayscale frame held in external host memory and writes one 8-bit LBP code per interior pixel to the result memory. It adds four things: a generic frame size and pixel width, a sliding 3x3 window (3 reads per pixel instead of 9 after the first column of each row), a programmable comparison threshold, and optional zero-filling of border pixels. It sits between the gray-image memory port and the LBP result memory port, in place of the fixed 128x128 engine.

## Interface
Parameters:
- COL_BITS, 7, log2 of frame width W (W = 2^COL_BITS, minimum 4)
- ROW_BITS, 7, log2 of frame height H (H = 2^ROW_BITS, minimum 4)
- PIX_W, 8, gray pixel width in bits
- BORDER_WRITE, 0, 1 = write code 0 to every border pixel after the interior scan

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- gray_ready  in  1  frame available; sampled only in IDLE
- thr  in  PIX_W  comparison threshold; captured on the IDLE->LOAD transition
- gray_addr  out  COL_BITS+ROW_BITS  read address {row,col}
- gray_req  out  1  read strobe; one address per cycle while high
- gray_data  in  PIX_W  read data, valid the cycle after the request
- lbp_addr  out  COL_BITS+ROW_BITS  write address {row,col}
- lbp_valid  out  1  write strobe, one cycle per code
- lbp_data  out  8  LBP code
- finish  out  1  frame complete; held high until reset

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, and the window position resets to (row=1, col=1).
- States and transitions:
  - IDLE: go to LOAD when gray_ready=1.
  - LOAD: issue 9 reads at the start of each row, then go to WRITE.
  - SHIFT: issue 3 reads for the new right column, then go to WRITE.
  - WRITE: go to SHIFT if col<W-2, with col+1. At the end of a row (col=W-2) go to LOAD with row+1, col=1. After the last interior pixel (row=H-2, col=W-2) go to BORDER if BORDER_WRITE=1, else DONE.
  - BORDER: go to DONE after the last border write.
  - DONE: terminal state; only reset leaves it.
- LOAD read order: (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c),(r,c+1),(r+1,c-1),(r+1,c),(r+1,c+1).
- SHIFT read order: (r-1,c+1),(r,c+1),(r+1,c+1), where c is the new column. On each SHIFT the window shifts left one column before the new column is captured.
- Comparison: bit = (neighbor >= center + thr). The sum is computed in PIX_W+1 bits with no saturation, so if center+thr > 2^PIX_W-1 every bit is 0.
- Code bit order: bit0 (r-1,c-1), bit1 (r-1,c), bit2 (r-1,c+1), bit3 (r,c-1), bit4 (r,c+1), bit5 (r+1,c-1), bit6 (r+1,c), bit7 (r+1,c+1).
- BORDER: write lbp_data=0 once to every address with row∈{0,H-1} or col∈{0,W-1}, one per cycle, in ascending raster address order. This is 2W+2(H-2) writes.
- Changes to gray_ready or thr after leaving IDLE are ignored.

## Timing
- Read protocol: in a cycle with gray_req=1, gray_addr is presented; gray_data for that address is captured on the next rising edge. No wait states.
- LOAD: 9 request cycles plus 1 drain cycle (gray_req=0) = 10 cycles.
- SHIFT: 3 request cycles plus 1 drain cycle = 4 cycles.
- WRITE: 1 cycle with lbp_valid=1. lbp_addr and lbp_data are stable that cycle. gray_req=0.
- Per row: 11 + 5·(W-3) cycles. The interior phase lasts exactly (H-2)·(11+5·(W-3)) cycles from the first LOAD cycle to the cycle after the last WRITE. For 128x128 that is 80136 cycles.
- BORDER: lbp_valid=1 on every cycle, 2W+2(H-2) consecutive cycles.
- finish rises the cycle after entering DONE and stays 1. lbp_valid=0 and gray_req=0 in DONE.
- Reset asserted in any state:
  - on the next edge all outputs return to 0 and the state returns to IDLE;
  - any read in flight is discarded;
  - no lbp_valid pulse occurs in the reset cycle or the cycle after.

## Test plan
- 128x128 all pixels 50, thr=0: 15876 writes, all lbp_data=0xFF. First lbp_addr=129, last 16254. finish rises 80136 cycles after the first LOAD cycle.
- Centre 100, neighbors 101,99,100,0,255,100,99,101, thr=0 -> code 0b10110101=0xB5. Same window with thr=1 -> 0b10010001=0x91.
- Overflow: center 250, thr=10, all neighbors 255 -> code 0x00.
- COL_BITS=ROW_BITS=2, BORDER_WRITE=1: 4 interior writes at addresses 5,6,9,10, then 12 border writes of 0 at 0,1,2,3,4,7,8,11,12,13,14,15, then finish.
- Reset pulsed mid-SHIFT at row 3: all outputs 0 next cycle, no stray lbp_valid. The restarted scan reproduces the golden output from address 129.
- Read-order check: log gray_addr per row. Expect 9 addresses at col=1, then exactly 3 per column, with no re-reads.

Source files
------------

// File: rtl/lbp_scan_engine.sv
// lbp_scan_engine
//   Scans a 2^ROW_BITS x 2^COL_BITS grayscale frame held in host memory and
//   writes one 8-bit Local Binary Pattern code per interior pixel. A sliding
//   3x3 window is used: 9 reads at the start of each row, then 3 reads per
//   step for the new right-hand column. Each neighbour bit is
//   (neighbour >= centre + thr), with the sum held in PIX_W+1 bits. When
//   BORDER_WRITE is set, every border pixel then gets code 0 in ascending
//   address order.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   gray_ready frame available, looked at only while idle
//   thr        comparison threshold, captured when the scan starts
//   gray_addr  read address {row,col}
//   gray_req   read strobe, one address per cycle
//   gray_data  read data, valid the cycle after the request
//   lbp_addr   write address {row,col}
//   lbp_valid  write strobe, one cycle per code
//   lbp_data   LBP code
//   finish     frame complete, held until reset
module lbp_scan_engine #(
  parameter int COL_BITS     = 7,
  parameter int ROW_BITS     = 7,
  parameter int PIX_W        = 8,
  parameter int BORDER_WRITE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gray_ready,
  input  logic [PIX_W-1:0]             thr,
  output logic [ROW_BITS+COL_BITS-1:0] gray_addr,
  output logic                         gray_req,
  input  logic [PIX_W-1:0]             gray_data,
  output logic [ROW_BITS+COL_BITS-1:0] lbp_addr,
  output logic                         lbp_valid,
  output logic [7:0]                   lbp_data,
  output logic                         finish
);

  localparam int AW = ROW_BITS + COL_BITS;
  localparam logic [COL_BITS-1:0] COL_ONE = {{(COL_BITS-1){1'b0}}, 1'b1};
  localparam logic [COL_BITS-1:0] COL_END = {{(COL_BITS-1){1'b1}}, 1'b0};
  localparam logic [COL_BITS-1:0] COL_MAX = '1;
  localparam logic [ROW_BITS-1:0] ROW_ONE = {{(ROW_BITS-1){1'b0}}, 1'b1};
  localparam logic [ROW_BITS-1:0] ROW_END = {{(ROW_BITS-1){1'b1}}, 1'b0};
  localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
  localparam logic [AW-1:0]       ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WRITE, BORDER, DONE} state_t;

  state_t              state;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [3:0]          cnt;
  logic [PIX_W-1:0]    thr_q;
  // Window in raster order: 0..2 top row, 3..5 middle, 6..8 bottom.
  logic [PIX_W-1:0]    win [0:8];
  logic [PIX_W:0]      limit;
  logic [7:0]          code;

  // Address of the k-th read around window centre (r,c). A row load walks the
  // full 3x3 block; a shift only fetches the right-hand column.
  function automatic logic [AW-1:0] rd_addr(input logic [ROW_BITS-1:0] r,
                                            input logic [COL_BITS-1:0] c,
                                            input logic [3:0] k,
                                            input logic shift);
    logic [1:0] dr;
    logic [1:0] dc;
    dr = 2'd0;
    dc = 2'd0;
    if (shift) begin
      dr = k[1:0];
      dc = 2'd2;
    end else begin
      case (k)
        4'd1: dc = 2'd1;
        4'd2: dc = 2'd2;
        4'd3: dr = 2'd1;
        4'd4: begin dr = 2'd1; dc = 2'd1; end
        4'd5: begin dr = 2'd1; dc = 2'd2; end
        4'd6: dr = 2'd2;
        4'd7: begin dr = 2'd2; dc = 2'd1; end
        4'd8: begin dr = 2'd2; dc = 2'd2; end
        default: ;
      endcase
    end
    rd_addr = {r + {{(ROW_BITS-2){1'b0}}, dr} - ROW_ONE,
               c + {{(COL_BITS-2){1'b0}}, dc} - COL_ONE};
  endfunction

  // Next border address in raster order: interior rows jump from column 0
  // straight to the last column; everything else simply increments.
  function automatic logic [AW-1:0] border_next(input logic [AW-1:0] a);
    logic [ROW_BITS-1:0] br;
    logic [COL_BITS-1:0] bc;
    {br, bc} = a;
    if (br != '0 && br != ROW_MAX && bc == '0)
      border_next = {br, COL_MAX};
    else
      border_next = a + ADDR_ONE;
  endfunction

  // The bottom-right neighbour is the last read of both LOAD and SHIFT and
  // arrives on the edge that enters WRITE, so it is taken straight from the
  // read bus rather than from the window.
  always_comb begin
    limit   = {1'b0, win[4]} + {1'b0, thr_q};
    code    = 8'h00;
    code[0] = ({1'b0, win[0]}    >= limit);
    code[1] = ({1'b0, win[1]}    >= limit);
    code[2] = ({1'b0, win[2]}    >= limit);
    code[3] = ({1'b0, win[3]}    >= limit);
    code[4] = ({1'b0, win[5]}    >= limit);
    code[5] = ({1'b0, win[6]}    >= limit);
    code[6] = ({1'b0, win[7]}    >= limit);
    code[7] = ({1'b0, gray_data} >= limit);
  end

  // Scan controller. Read strobes and addresses are registered, so each state
  // programs the request for the following cycle; read data lands one cycle
  // behind its request, which is why captures use cnt-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= ROW_ONE;
      col       <= COL_ONE;
      cnt       <= '0;
      thr_q     <= '0;
      gray_addr <= '0;
      gray_req  <= 1'b0;
      lbp_addr  <= '0;
      lbp_valid <= 1'b0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gray_ready) begin
            thr_q     <= thr;
            state     <= LOAD;
            cnt       <= '0;
            gray_req  <= 1'b1;
            gray_addr <= rd_addr(row, col, 4'd0, 1'b0);
          end
        end
        LOAD: begin
          if (cnt != 4'd0) win[cnt - 4'd1] <= gray_data;
          if (cnt < 4'd8) begin
            gray_req  <= 1'b1;
            gray_addr <= rd_addr(row, col, cnt + 4'd1, 1'b0);
          end else begin
            gray_req <= 1'b0;
          end
          if (cnt == 4'd9) begin
            state     <= WRITE;
            lbp_valid <= 1'b1;
            lbp_addr  <= {row, col};
            lbp_data  <= code;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SHIFT: begin
          case (cnt)
            4'd1: win[2] <= gray_data;
            4'd2: win[5] <= gray_data;
            4'd3: win[8] <= gray_data;
            default: ;
          endcase
          if (cnt < 4'd2) begin
            gray_req  <= 1'b1;
            gray_addr <= rd_addr(row, col, cnt + 4'd1, 1'b1);
          end else begin
            gray_req <= 1'b0;
          end
          if (cnt == 4'd3) begin
            state     <= WRITE;
            lbp_valid <= 1'b1;
            lbp_addr  <= {row, col};
            lbp_data  <= code;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          lbp_valid <= 1'b0;
          cnt       <= '0;
          if (col != COL_END) begin
            col       <= col + COL_ONE;
            state     <= SHIFT;
            win[0]    <= win[1];
            win[1]    <= win[2];
            win[3]    <= win[4];
            win[4]    <= win[5];
            win[6]    <= win[7];
            win[7]    <= win[8];
            gray_req  <= 1'b1;
            gray_addr <= rd_addr(row, col + COL_ONE, 4'd0, 1'b1);
          end else if (row != ROW_END) begin
            row       <= row + ROW_ONE;
            col       <= COL_ONE;
            state     <= LOAD;
            gray_req  <= 1'b1;
            gray_addr <= rd_addr(row + ROW_ONE, COL_ONE, 4'd0, 1'b0);
          end else if (BORDER_WRITE != 0) begin
            state     <= BORDER;
            lbp_valid <= 1'b1;
            lbp_addr  <= '0;
            lbp_data  <= '0;
          end else begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        BORDER: begin
          if (lbp_addr == '1) begin
            state     <= DONE;
            lbp_valid <= 1'b0;
            finish    <= 1'b1;
          end else begin
            lbp_addr <= border_next(lbp_addr);
          end
        end
        DONE: begin
          gray_req  <= 1'b0;
          lbp_valid <= 1'b0;
          finish    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_scan_engine.sv
// Testbench for lbp_scan_engine. Two instances share one clock: a 16x8 frame
// without border fill and a 4x4 frame with border fill. Each has a simple
// registered memory model; results are compared against a reference model
// that computes codes and access orders directly from pixel arithmetic.
module tb_lbp_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetA, resetB, readyA, readyB;
  logic [7:0] thr;

  logic [6:0] gaddrA, laddrA;
  logic       reqA, validA, finA;
  logic [7:0] gdataA, ldataA;
  logic [3:0] gaddrB, laddrB;
  logic       reqB, validB, finB;
  logic [7:0] gdataB, ldataB;

  logic [7:0] memA [0:127];
  logic [7:0] memB [0:15];

  lbp_scan_engine #(.COL_BITS(4), .ROW_BITS(3), .PIX_W(8), .BORDER_WRITE(0)) dutA (
    .clk(clk), .reset(resetA), .gray_ready(readyA), .thr(thr),
    .gray_addr(gaddrA), .gray_req(reqA), .gray_data(gdataA),
    .lbp_addr(laddrA), .lbp_valid(validA), .lbp_data(ldataA), .finish(finA));

  lbp_scan_engine #(.COL_BITS(2), .ROW_BITS(2), .PIX_W(8), .BORDER_WRITE(1)) dutB (
    .clk(clk), .reset(resetB), .gray_ready(readyB), .thr(thr),
    .gray_addr(gaddrB), .gray_req(reqB), .gray_data(gdataB),
    .lbp_addr(laddrB), .lbp_valid(validB), .lbp_data(ldataB), .finish(finB));

  // Host memories: address sampled on the edge, data valid the following cycle.
  initial begin
    gdataA = 8'h00;
    gdataB = 8'h00;
  end
  always @(posedge clk) begin
    if (reqA) gdataA <= memA[gaddrA];
    if (reqB) gdataB <= memB[gaddrB];
  end

  // Observation mux so one scan task serves either instance.
  logic       selA;
  logic [6:0] mGaddr, mLaddr;
  logic       mReq, mValid, mFin;
  logic [7:0] mData;
  always_comb begin
    if (selA) begin
      mGaddr = gaddrA; mLaddr = laddrA; mReq = reqA;
      mValid = validA; mFin = finA; mData = ldataA;
    end else begin
      mGaddr = {3'b000, gaddrB}; mLaddr = {3'b000, laddrB}; mReq = reqB;
      mValid = validB; mFin = finB; mData = ldataB;
    end
  end

  int nCompared = 0;
  int nMismatched = 0;
  int gotW[$], gotR[$], expW[$], expR[$];

  typedef struct {
    int center;
    int nb[8];
    int t;
    int code;
  } vec_t;
  vec_t vecs[6];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkQueue(input string name, input int got[$], input int exp[$]);
    int idx;
    idx = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (idx < 0 && got[i] != exp[i]) idx = i;
    nCompared++;
    if (idx >= 0) begin
      nMismatched++;
      $display("[TB] FAIL %s: entry %0d got %0d, expected %0d", name, idx, got[idx], exp[idx]);
    end else if (got.size() != exp.size()) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d entries, expected %0d", name, got.size(), exp.size());
    end
  endtask

  function automatic int pix(input bit a, input int r, input int c);
    return a ? int'(memA[r*16 + c]) : int'(memB[r*4 + c]);
  endfunction

  // Reference LBP: plain integer sum, so centre+thr beyond 255 clears every bit.
  function automatic int lbpRef(input bit a, input int r, input int c, input int t);
    int lim;
    int code;
    int b;
    lim  = pix(a, r, c) + t;
    code = 0;
    b    = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0)) begin
          if (pix(a, r + dr, c + dc) >= lim) code = code | (1 << b);
          b++;
        end
    return code;
  endfunction

  task automatic buildExpected(input bit a, input int t);
    int w, h;
    w = a ? 16 : 4;
    h = a ? 8 : 4;
    expW.delete();
    expR.delete();
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++) begin
        expW.push_back((r*w + c)*256 + lbpRef(a, r, c, t));
        if (c == 1) begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) expR.push_back((r + dr)*w + c + dc);
        end else begin
          for (int dr = -1; dr <= 1; dr++) expR.push_back((r + dr)*w + c + 1);
        end
      end
    if (!a)
      for (int ad = 0; ad < w*h; ad++)
        if (ad / w == 0 || ad / w == h - 1 || ad % w == 0 || ad % w == w - 1)
          expW.push_back(ad*256);
  endtask

  // Runs one frame. abortAt >= 0 pulses reset that many cycles after the
  // first read and checks the outputs instead of completing the frame.
  task automatic applyStimulus(input bit a, input logic [7:0] t, input bit doReset,
                               input int abortAt, input string tag);
    int w, h, first, fin, cyc, lat;
    bit aborted;
    w = a ? 16 : 4;
    h = a ? 8 : 4;
    selA = a;
    if (doReset) begin
      if (a) resetA = 1'b1; else resetB = 1'b1;
      @(negedge clk);
      @(negedge clk);
      resetA = 1'b0;
      resetB = 1'b0;
    end
    thr = t;
    if (a) readyA = 1'b1; else readyB = 1'b1;
    gotW.delete();
    gotR.delete();
    first = -1;
    fin = -1;
    cyc = 0;
    aborted = 1'b0;
    while (cyc < 4000 && fin < 0 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (mReq) begin
        gotR.push_back(int'(mGaddr));
        if (first < 0) begin
          first = cyc;
          readyA = 1'b0;
          readyB = 1'b0;
          thr = 8'($urandom_range(0, 255));
        end
      end
      if (mValid) gotW.push_back(int'(mLaddr)*256 + int'(mData));
      if (mFin) fin = cyc;
      if (abortAt >= 0 && first >= 0 && cyc == first + abortAt) aborted = 1'b1;
    end
    if (aborted) begin
      if (a) resetA = 1'b1; else resetB = 1'b1;
      @(negedge clk);
      checkOutput({tag, " outputs_in_reset"},
                  {mReq, mGaddr, mValid, mLaddr, mData, mFin}, 0);
      resetA = 1'b0;
      resetB = 1'b0;
      @(negedge clk);
      checkOutput({tag, " quiet_after_reset"}, {mValid, mReq, mFin}, 0);
    end else begin
      buildExpected(a, int'(t));
      lat = (h - 2)*(11 + 5*(w - 3)) + (a ? 0 : 2*w + 2*(h - 2));
      checkOutput({tag, " finish_latency"}, (fin < 0) ? -1 : fin - first, lat);
      checkQueue({tag, " writes"}, gotW, expW);
      checkQueue({tag, " reads"}, gotR, expR);
      repeat (3) @(negedge clk);
      checkOutput({tag, " done_hold"}, {mFin, mValid, mReq}, 3'b100);
    end
  endtask

  initial begin
    int pos[8];
    int seqB[$];
    int addrB[$];
    pos = '{0, 1, 2, 4, 6, 8, 9, 10};
    vecs[0] = '{100, '{101, 99, 100, 0, 255, 100, 99, 101}, 0, 8'hB5};
    vecs[1] = '{100, '{101, 99, 100, 0, 255, 100, 99, 101}, 1, 8'h91};
    vecs[2] = '{250, '{255, 255, 255, 255, 255, 255, 255, 255}, 10, 8'h00};
    vecs[3] = '{50, '{50, 50, 50, 50, 50, 50, 50, 50}, 0, 8'hFF};
    vecs[4] = '{0, '{255, 255, 255, 255, 255, 255, 255, 255}, 255, 8'hFF};
    vecs[5] = '{5, '{4, 5, 6, 0, 200, 5, 4, 6}, 0, 8'hB6};

    resetA = 1'b1; resetB = 1'b1; readyA = 1'b0; readyB = 1'b0;
    thr = 8'h00; selA = 1'b1;
    for (int i = 0; i < 128; i++) memA[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) memB[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state_A", {reqA, gaddrA, validA, laddrA, ldataA, finA}, 0);
    checkOutput("reset_state_B", {reqB, gaddrB, validB, laddrB, ldataB, finB}, 0);
    resetA = 1'b0;
    resetB = 1'b0;
    @(negedge clk);

    $display("[TB] flat frame, thr=0");
    for (int i = 0; i < 128; i++) memA[i] = 8'd50;
    applyStimulus(1'b1, 8'd0, 1'b1, -1, "flat50");
    checkOutput("flat50 count", gotW.size(), 84);
    checkOutput("flat50 first_addr", gotW[0] / 256, 17);
    checkOutput("flat50 last_addr", gotW[gotW.size() - 1] / 256, 110);
    checkOutput("flat50 first_code", gotW[0] % 256, 255);

    $display("[TB] window vectors on 4x4 frame");
    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) memB[i] = 8'($urandom_range(0, 255));
      memB[5] = 8'(vecs[v].center);
      for (int i = 0; i < 8; i++) memB[pos[i]] = 8'(vecs[v].nb[i]);
      applyStimulus(1'b0, 8'(vecs[v].t), 1'b1, -1, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d addr", v), gotW[0] / 256, 5);
      checkOutput($sformatf("vec%0d code", v), gotW[0] % 256, vecs[v].code);
      if (v == 0) begin
        seqB = '{5, 6, 9, 10, 0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15};
        addrB.delete();
        foreach (gotW[i]) addrB.push_back(gotW[i] / 256);
        checkQueue("vec0 address_order", addrB, seqB);
      end
    end

    $display("[TB] random frames on 16x8");
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 128; i++)
        memA[i] = (f % 2 == 0) ? 8'($urandom_range(90, 110)) : 8'($urandom_range(0, 255));
      applyStimulus(1'b1, (f == 4) ? 8'd250 : 8'($urandom_range(0, 12)), 1'b1, -1,
                    $sformatf("rand%0d", f));
    end

    $display("[TB] reset mid-SHIFT on row 3, then restart");
    for (int i = 0; i < 128; i++) memA[i] = 8'($urandom_range(80, 120));
    applyStimulus(1'b1, 8'd3, 1'b1, 2*76 + 12, "midreset");
    applyStimulus(1'b1, 8'd3, 1'b0, -1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
